// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: registered N-bit ripple-carry adder built from a chain of
// 1-bit full-adder cells.
//
// Parameters:
//   WIDTH      operand/sum width in bits (2..64)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every register
//   in_valid   qualifies a, b, cin this cycle
//   a, b       operands (unsigned or two's complement)
//   cin        carry into bit 0
//   sum        registered a+b+cin modulo 2^WIDTH
//   cout       registered carry out of bit WIDTH-1
//   ovf        registered signed overflow (carry into MSB ^ carry out of MSB)
//   out_valid  sum/cout/ovf hold a new result this cycle
//
// Build option:
//   RCA_PIPE_EN  when defined, splits the chain into two register stages
//                (low WIDTH/2 bits, then the rest); latency 2, throughput 1.
//                When undefined, latency is 1.

module ripple_carry_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q;

`ifdef RCA_PIPE_EN

  localparam int unsigned Lo = WIDTH / 2;
  localparam int unsigned Hi = WIDTH - Lo;

  // Stage 1: ripple the low half.
  logic [Lo:0]   c_lo;
  logic [Lo-1:0] s_lo;

  assign c_lo[0] = cin;

  for (genvar i = 0; i < Lo; i++) begin : g_fa_lo
    assign s_lo[i]   = a[i] ^ b[i] ^ c_lo[i];
    assign c_lo[i+1] = (a[i] & b[i]) | (c_lo[i] & (a[i] ^ b[i]));
  end

  logic [Lo-1:0] lo_sum_q, lo_sum_d;
  logic          carry_q, carry_d;
  logic [Hi-1:0] a_hi_q, a_hi_d;
  logic [Hi-1:0] b_hi_q, b_hi_d;
  logic          v1_q;

  // Stage-1 registers only load on valid so idle inputs never toggle them.
  always_comb begin
    lo_sum_d = lo_sum_q;
    carry_d  = carry_q;
    a_hi_d   = a_hi_q;
    b_hi_d   = b_hi_q;
    if (in_valid) begin
      lo_sum_d = s_lo;
      carry_d  = c_lo[Lo];
      a_hi_d   = a[WIDTH-1:Lo];
      b_hi_d   = b[WIDTH-1:Lo];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum_q <= '0;
      carry_q  <= 1'b0;
      a_hi_q   <= '0;
      b_hi_q   <= '0;
      v1_q     <= 1'b0;
    end else begin
      lo_sum_q <= lo_sum_d;
      carry_q  <= carry_d;
      a_hi_q   <= a_hi_d;
      b_hi_q   <= b_hi_d;
      v1_q     <= in_valid;
    end
  end

  // Stage 2: ripple the high part from the registered carry.
  logic [Hi:0]   c_hi;
  logic [Hi-1:0] s_hi;

  assign c_hi[0] = carry_q;

  for (genvar i = 0; i < Hi; i++) begin : g_fa_hi
    assign s_hi[i]   = a_hi_q[i] ^ b_hi_q[i] ^ c_hi[i];
    assign c_hi[i+1] = (a_hi_q[i] & b_hi_q[i]) | (c_hi[i] & (a_hi_q[i] ^ b_hi_q[i]));
  end

  // c_hi[Hi-1] is the carry into the MSB; for Hi==1 it is the stage-1 carry.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (v1_q) begin
      sum_d  = {s_hi, lo_sum_q};
      cout_d = c_hi[Hi];
      ovf_d  = c_hi[Hi-1] ^ c_hi[Hi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= v1_q;
    end
  end

`else

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  // Results only load on valid; otherwise the last result is held.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH-1] ^ c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= in_valid;
    end
  end

`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder (WIDTH=4): directed vectors, an
// exhaustive sweep, random traffic with gaps, and an asynchronous reset check.
module tb_ripple_carry_adder;

  localparam int unsigned W = 4;
`ifdef RCA_PIPE_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [W-1:0] last_s = '0;
  logic         last_co = 1'b0;
  logic         last_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, signed overflow from range check.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc);
    exp_t   e;
    longint u;
    longint sg;
    longint sa;
    longint sb;
    u  = longint'(ta) + longint'(tb) + longint'(tc);
    sa = ta[W-1] ? longint'(ta) - (longint'(1) << W) : longint'(ta);
    sb = tb[W-1] ? longint'(tb) - (longint'(1) << W) : longint'(tb);
    sg = sa + sb + longint'(tc);
    e.s  = W'(u);
    e.co = u[W];
    e.ov = (sg > ((longint'(1) << (W - 1)) - 1)) || (sg < -(longint'(1) << (W - 1)));
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of stimulus; invalid cycles carry random operands.
  task automatic issue(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc);
    exp_t e;
    in_valid = v;
    a = v ? ta : W'($urandom);
    b = v ? tb : W'($urandom);
    cin = v ? tc : 1'($urandom);
    if (v) begin
      e = model(ta, tb, tc);
      e.cyc = cyc + Lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on out_valid; on idle cycles the held result must not move.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_s  = '0;
      last_co = 1'b0;
      last_ov = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check("sum", 64'(sum), 64'(e.s));
        check("cout", 64'(cout), 64'(e.co));
        check("ovf", 64'(ovf), 64'(e.ov));
        check("latency", 64'(cyc), 64'(e.cyc));
        last_s  = e.s;
        last_co = e.co;
        last_ov = e.ov;
      end
    end else begin
      check("hold_sum", 64'(sum), 64'(last_s));
      check("hold_cout", 64'(cout), 64'(last_co));
      check("hold_ovf", 64'(ovf), 64'(last_ov));
    end
  end

  initial begin
    // Power-on reset.
    #1;
    check("por_sum", 64'(sum), 64'd0);
    check("por_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors back-to-back, then idle with random operands.
    issue(1'b1, 4'b0011, 4'b0101, 1'b0);
    issue(1'b1, 4'b1111, 4'b0001, 1'b0);
    issue(1'b1, 4'b1010, 4'b0101, 1'b1);
    issue(1'b1, 4'b0110, 4'b0011, 1'b0);
    issue(1'b1, 4'b0000, 4'b0000, 1'b0);
    repeat (4) issue(1'b0, '0, '0, 1'b0);

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 512; i++) begin
      issue(1'b1, W'(i[3:0]), W'(i[7:4]), i[8]);
    end
    repeat (3) issue(1'b0, '0, '0, 1'b0);

    // Random traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 2) != 0), W'($urandom), W'($urandom), 1'($urandom));
    end
    repeat (Lat + 2) issue(1'b0, '0, '0, 1'b0);

    // Make outputs nonzero, then reset mid-cycle with an op in flight.
    issue(1'b1, 4'b1111, 4'b0111, 1'b1);
    repeat (Lat + 1) issue(1'b0, '0, '0, 1'b0);
    check("pre_reset_sum", 64'(sum), 64'h7);
    in_valid = 1'b1;
    a = 4'b1001;
    b = 4'b1001;
    cin = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (Lat + 2) issue(1'b0, '0, '0, 1'b0);

    // Traffic resumes cleanly after reset.
    issue(1'b1, 4'b0110, 4'b0011, 1'b0);
    issue(1'b1, 4'b1111, 4'b0000, 1'b1);
    repeat (Lat + 2) issue(1'b0, '0, '0, 1'b0);

    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
